// File: rtl/apc_pkg.sv
// Shared definitions for the approximate parallel counter (APC) pipeline.
// Holds the counter geometry, the helper functions that size the window
// accumulator, and the state type of the accumulator FSM.
package apc_pkg;

    localparam int unsigned APC_N = 32;  // bitstream inputs per APC
    localparam int unsigned APC_W = 6;   // width of the APC per-cycle count

    // Accumulator width: large enough for 63 * window without wrapping.
    function automatic int unsigned sum_width(input int unsigned window);
        return APC_W + $clog2(window);
    endfunction

    // Width of a sample count that can reach the full window length.
    function automatic int unsigned len_width(input int unsigned window);
        return $clog2(window + 1);
    endfunction

    typedef enum logic {
        ACCUM,
        FLUSH_PEND
    } acc_state_e;

endpackage

// File: rtl/apc_out_slot.sv
// One-entry valid/ready output register.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load          capture load_data this cycle (caller only loads when slot_free)
//   load_data     data to capture
//   out_ready     consumer accepts the held entry
//   slot_free     slot can take a load this cycle (empty, or draining now)
//   out_valid     entry held
//   out_data      held entry, stable until drained
module apc_out_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              slot_free,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Same-cycle drain lets a full slot accept a new entry without a bubble.
    assign slot_free = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/apc_window_accumulator.sv
// Integrate-and-fire stage behind the APC: sums per-cycle counts over a
// window of WINDOW accepted samples (or fewer on an early flush) and hands
// {sum, length, fire} to a one-entry valid/ready output slot.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     input handshake for in_count
//   in_count              APC count, 0..63, taken unclamped
//   flush                 one-cycle pulse closing the current window early
//   out_valid/out_ready   output handshake
//   out_sum               window sum
//   out_len               samples in the window (1..WINDOW)
//   out_fire              out_sum >= THRESH
module apc_window_accumulator
    import apc_pkg::*;
#(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned THRESH = 256,
    parameter int unsigned SUM_W  = sum_width(WINDOW),
    parameter int unsigned LEN_W  = len_width(WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [APC_W-1:0] in_count,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [LEN_W-1:0] out_len,
    output logic             out_fire
);

    localparam int unsigned SLOT_W = SUM_W + LEN_W + 1;
    localparam logic [LEN_W-1:0] LAST_CNT   = LEN_W'(WINDOW - 1);
    localparam logic [LEN_W-1:0] WINDOW_LEN = LEN_W'(WINDOW);

    acc_state_e       state_q, state_d;
    logic [SUM_W-1:0] acc_q,   acc_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;

    logic              slot_free;
    logic              slot_load;
    logic [SUM_W-1:0]  load_sum;
    logic [LEN_W-1:0]  load_len;
    logic              load_fire;
    logic [SLOT_W-1:0] slot_data;

    logic              accept;
    logic              full_close;
    logic              flush_close;
    logic [SUM_W-1:0]  sum_next;
    logic [LEN_W-1:0]  cnt_next;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready    = 1'b0;
        slot_load   = 1'b0;
        load_sum    = acc_q;
        load_len    = cnt_q;
        accept      = 1'b0;
        full_close  = 1'b0;
        flush_close = 1'b0;
        sum_next    = acc_q + SUM_W'(in_count);
        cnt_next    = cnt_q + LEN_W'(1);

        unique case (state_q)
            ACCUM: begin
                // Only the window-closing sample needs room in the slot.
                in_ready    = !rst && ((cnt_q != LAST_CNT) || slot_free);
                accept      = in_valid && in_ready;
                full_close  = accept && (cnt_q == LAST_CNT);
                flush_close = flush && ((cnt_q != '0) || accept);

                if (full_close) begin
                    // A flush on the closing sample merges into this close.
                    slot_load = 1'b1;
                    load_sum  = sum_next;
                    load_len  = WINDOW_LEN;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else if (flush_close) begin
                    load_sum = accept ? sum_next : acc_q;
                    load_len = accept ? cnt_next : cnt_q;
                    if (slot_free) begin
                        slot_load = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        // Park the closed window in acc/cnt until the slot drains.
                        acc_d   = load_sum;
                        cnt_d   = load_len;
                        state_d = FLUSH_PEND;
                    end
                end else if (accept) begin
                    acc_d = sum_next;
                    cnt_d = cnt_next;
                end
            end

            FLUSH_PEND: begin
                if (slot_free) begin
                    slot_load = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = ACCUM;
                end
            end

            default: state_d = ACCUM;
        endcase

        load_fire = (32'(load_sum) >= THRESH);
        slot_data = {load_sum, load_len, load_fire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [SLOT_W-1:0] out_data;

    apc_out_slot #(
        .DATA_W (SLOT_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .load_data (slot_data),
        .out_ready (out_ready),
        .slot_free (slot_free),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    assign out_sum  = out_data[SLOT_W-1 -: SUM_W];
    assign out_len  = out_data[LEN_W:1];
    assign out_fire = out_data[0];

endmodule

// File: tb/tb_apc_window_accumulator.sv
module tb_apc_window_accumulator;

    localparam int unsigned WINDOW = 4;
    localparam int unsigned THRESH = 64;
    localparam int unsigned SUM_W  = 8;
    localparam int unsigned LEN_W  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [5:0]       in_count = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SUM_W-1:0] out_sum;
    logic [LEN_W-1:0] out_len;
    logic             out_fire;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    apc_window_accumulator #(
        .WINDOW (WINDOW),
        .THRESH (THRESH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_len   (out_len),
        .out_fire  (out_fire)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled mid-low-phase.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Present one sample (optionally with flush), confirm it is accepted, clock it.
    task automatic feed(input string tag, input int unsigned c, input logic fl);
        in_valid = 1'b1;
        in_count = 6'(c);
        flush    = fl;
        #1;
        check(tag, 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int unsigned s, input int unsigned l,
                              input int unsigned f);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_sum"},   32'(out_sum),   s);
        check({tag, "_len"},   32'(out_len),   l);
        check({tag, "_fire"},  32'(out_fire),  f);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        step();
        step();
        in_valid = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_sum",   32'(out_sum),   0);
        check("rst_len",   32'(out_len),   0);
        check("rst_fire",  32'(out_fire),  0);
        rst = 1'b0;
        step();

        // 1: back-to-back full window, consumer always ready
        out_ready = 1'b1;
        feed("t1_rdy0", 10, 1'b0);
        feed("t1_rdy1", 20, 1'b0);
        feed("t1_rdy2", 30, 1'b0);
        feed("t1_rdy3", 5,  1'b0);
        expect_out("t1", 65, 4, 1);
        step();
        check("t1_drained", 32'(out_valid), 0);

        // 2: backpressure on the window-closing sample
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed("t2_w1", 1, 1'b0);
        expect_out("t2_w1", 4, 4, 0);
        for (int i = 0; i < 3; i++) feed("t2_w2", 2, 1'b0);
        in_valid = 1'b1;
        in_count = 6'd2;
        #1;
        check("t2_stall_rdy", 32'(in_ready), 0);
        step();
        check("t2_stall_rdy2", 32'(in_ready), 0);
        check("t2_held_sum", 32'(out_sum), 4);
        out_ready = 1'b1;
        #1;
        check("t2_release_rdy", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        expect_out("t2_w2", 8, 4, 0);
        step();
        check("t2_drained", 32'(out_valid), 0);

        // 3: early flush, then a flush on an empty window
        feed("t3_s0", 7, 1'b0);
        feed("t3_s1", 9, 1'b0);
        pulse_flush();
        expect_out("t3", 16, 2, 0);
        step();
        check("t3_drained", 32'(out_valid), 0);
        pulse_flush();
        check("t3_empty_flush", 32'(out_valid), 0);
        step();
        check("t3_empty_flush2", 32'(out_valid), 0);

        // Threshold boundary: 64 fires, 63 does not; flush with same-cycle sample
        feed("th_s0", 63, 1'b0);
        feed("th_s1", 1,  1'b1);
        expect_out("th64", 64, 2, 1);
        feed("th_s2", 63, 1'b1);
        expect_out("th63", 63, 1, 0);
        step();
        check("th_drained", 32'(out_valid), 0);

        // 4: flush while the slot is held -> FLUSH_PEND
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed("t4_w1", 1, 1'b0);
        for (int i = 0; i < 3; i++) feed("t4_w2", 1, 1'b0);
        pulse_flush();
        in_valid = 1'b1;
        in_count = 6'd5;
        #1;
        check("t4_pend_rdy", 32'(in_ready), 0);
        check("t4_held_sum", 32'(out_sum), 4);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        expect_out("t4", 3, 3, 0);
        step();
        check("t4_drained", 32'(out_valid), 0);
        #1;
        check("t4_accum_rdy", 32'(in_ready), 1);

        // 5: max counts, flush coinciding with the closing sample
        for (int i = 0; i < 3; i++) feed("t5_s", 63, 1'b0);
        feed("t5_last", 63, 1'b1);
        expect_out("t5", 252, 4, 1);
        step();
        check("t5_single0", 32'(out_valid), 0);
        step();
        check("t5_single1", 32'(out_valid), 0);

        // 6: reset with partial window and a held result
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed("t6_w1", 1, 1'b0);
        feed("t6_p0", 1, 1'b0);
        feed("t6_p1", 1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid", 32'(out_valid), 0);
        check("t6_sum",   32'(out_sum),   0);
        check("t6_len",   32'(out_len),   0);
        check("t6_fire",  32'(out_fire),  0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) feed("t6_w2", 1, 1'b0);
        expect_out("t6", 4, 4, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
